// File: rtl/sram_bank_arbiter_pkg.sv
// Shared types and default widths for the SRAM bank arbiter.
package sram_bank_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 8;
    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_FETCH_WIDTH = 4;
    localparam int unsigned DEF_OUT_DEPTH   = 2;

    typedef logic [DEF_FETCH_WIDTH-1:0][DEF_DATA_WIDTH-1:0] fetch_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_e;

endpackage

// File: rtl/sram_bank_arbiter_if.sv
// Requester and bank-side signals of the SRAM bank arbiter; slave = arbiter side.
interface sram_bank_arbiter_if #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FETCH_WIDTH = 4
);
    logic                                   wr_valid;
    logic                                   wr_ready;
    logic [ADDR_WIDTH-1:0]                  wr_addr;
    logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] wr_data;
    logic                                   rd_valid;
    logic                                   rd_ready;
    logic [ADDR_WIDTH-1:0]                  rd_addr;
    logic                                   rd_data_valid;
    logic                                   rd_data_ready;
    logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0]                  mem_addr_out;
    logic                                   mem_cen_out;
    logic                                   mem_wen_out;
    logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] mem_data_out;
    logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] mem_data_in;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_data_ready, mem_data_in,
        output wr_ready, rd_ready, rd_data_valid, rd_data,
               mem_addr_out, mem_cen_out, mem_wen_out, mem_data_out
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_data_ready, mem_data_in,
        input  wr_ready, rd_ready, rd_data_valid, rd_data,
               mem_addr_out, mem_cen_out, mem_wen_out, mem_data_out
    );

endinterface

// File: rtl/sram_bank_arbiter_rd_fifo.sv
// Read-return buffer: DEPTH-entry FIFO with simultaneous push/pop and synchronous flush.
module sram_bank_rd_fifo #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FETCH_WIDTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic                                   push,
    input  logic                                   pop,
    input  logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] push_data,
    output logic [$clog2(DEPTH+1)-1:0]             count,
    output logic                                   head_valid,
    output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] head_data
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][FETCH_WIDTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head reads as zero when empty so stale entries never leak out.
    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank between a writer and a reader.
// Optional perf counters (conflict_cnt, rd_stall_cnt) enabled by SRAM_BANK_ARB_PERF_EN.
module sram_bank_arbiter
    import sram_bank_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int unsigned OUT_DEPTH   = DEF_OUT_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_en,
    input  logic               flush,
`ifdef SRAM_BANK_ARB_PERF_EN
    output logic [15:0]        conflict_cnt,
    output logic [15:0]        rd_stall_cnt,
`endif
    sram_bank_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

    grant_e last_grant_q, last_grant_d;
    logic   rd_pend_q, rd_pend_d;
    logic   active, conflict, rd_can, wr_gnt, rd_gnt, push, pop;
    logic   fifo_valid;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occ;
    logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] fifo_head;

    assign active   = clk_en & ~flush;
    assign conflict = bus.wr_valid & bus.rd_valid;
    assign pop      = fifo_valid & bus.rd_data_ready & active;
    assign push     = rd_pend_q & active;

    // Credit check: buffered + in flight - leaving this cycle must leave room.
    assign occ    = (CW+1)'(fifo_count) + (CW+1)'(rd_pend_q) - (CW+1)'(pop);
    assign rd_can = active & (occ < (CW+1)'(OUT_DEPTH));

    always_comb begin
        wr_gnt       = 1'b0;
        rd_gnt       = 1'b0;
        last_grant_d = last_grant_q;
        if (conflict) begin
            if (!rd_can)                    wr_gnt = active;
            else if (last_grant_q == GNT_RD) wr_gnt = 1'b1;
            else                            rd_gnt = 1'b1;
            if (wr_gnt)      last_grant_d = GNT_WR;
            else if (rd_gnt) last_grant_d = GNT_RD;
        end else begin
            wr_gnt = bus.wr_valid & active;
            rd_gnt = bus.rd_valid & rd_can;
        end
        if (flush) last_grant_d = GNT_RD;
    end

    always_comb begin
        rd_pend_d = rd_pend_q;
        if (flush)       rd_pend_d = 1'b0;
        else if (clk_en) rd_pend_d = rd_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_RD;
            rd_pend_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

    sram_bank_rd_fifo #(
        .DEPTH      (OUT_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FETCH_WIDTH(FETCH_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .push_data (bus.mem_data_in),
        .count     (fifo_count),
        .head_valid(fifo_valid),
        .head_data (fifo_head)
    );

    assign bus.wr_ready      = wr_gnt;
    assign bus.rd_ready      = rd_gnt;
    assign bus.rd_data_valid = fifo_valid;
    assign bus.rd_data       = fifo_head;
    assign bus.mem_cen_out   = wr_gnt | rd_gnt;
    assign bus.mem_wen_out   = wr_gnt;
    assign bus.mem_addr_out  = wr_gnt ? bus.wr_addr : (rd_gnt ? bus.rd_addr : ADDR_WIDTH'(0));
    assign bus.mem_data_out  = wr_gnt ? bus.wr_data : '0;

`ifdef SRAM_BANK_ARB_PERF_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d, rd_stall_cnt_q, rd_stall_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        rd_stall_cnt_d = rd_stall_cnt_q;
        if (flush) begin
            conflict_cnt_d = '0;
            rd_stall_cnt_d = '0;
        end else if (clk_en) begin
            if (conflict && conflict_cnt_q != 16'hFFFF)
                conflict_cnt_d = conflict_cnt_q + 16'd1;
            if (bus.rd_valid && !rd_gnt && rd_stall_cnt_q != 16'hFFFF)
                rd_stall_cnt_d = rd_stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
            rd_stall_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            rd_stall_cnt_q <= rd_stall_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign rd_stall_cnt = rd_stall_cnt_q;
`endif

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed self-checking bench for sram_bank_arbiter with a behavioural SRAM bank.
module tb_sram_bank_arbiter;
    import sram_bank_arb_pkg::*;

    localparam fetch_t DA  = {4{16'hAAAA}};
    localparam fetch_t D20 = {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    localparam fetch_t D30 = {16'h3000, 16'h3001, 16'h3002, 16'h3003};
    localparam fetch_t D31 = {16'h3100, 16'h3101, 16'h3102, 16'h3103};
    localparam fetch_t D40 = {16'h4444, 16'h0040, 16'h4444, 16'h0040};

    logic clk = 1'b0;
    logic rst_n, clk_en, flush;
    int   checks = 0;
    int   errors = 0;

    sram_bank_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .FETCH_WIDTH(4)) bus();

`ifdef SRAM_BANK_ARB_PERF_EN
    logic [15:0] conflict_cnt, rd_stall_cnt;
`endif

    sram_bank_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .flush  (flush),
`ifdef SRAM_BANK_ARB_PERF_EN
        .conflict_cnt(conflict_cnt),
        .rd_stall_cnt(rd_stall_cnt),
`endif
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Behavioural bank: read data appears one cycle after the access.
    fetch_t bank [256];
    always @(posedge clk) begin
        if (bus.mem_cen_out) begin
            if (bus.mem_wen_out) bank[bus.mem_addr_out] <= bus.mem_data_out;
            else                 bus.mem_data_in <= bank[bus.mem_addr_out];
        end
    end

    // The return buffer must never be pushed while full unless it also pops.
    always @(posedge clk) begin
        if (rst_n && dut.u_fifo.push && !dut.u_fifo.pop && dut.u_fifo.count_q >= 2) begin
            errors++;
            $display("FAIL fifo_overflow: push while full, count %0d", dut.u_fifo.count_q);
        end
    end

    task automatic idle();
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_data_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        clk_en = 1'b1;
        flush  = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_data_valid: got %b exp 0", bus.rd_data_valid); end
        checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h exp 0", bus.rd_data); end
        checks++; if ({bus.wr_ready, bus.rd_ready, bus.mem_cen_out, bus.mem_wen_out} !== 4'b0) begin errors++; $display("FAIL reset_grants: got %b exp 0000", {bus.wr_ready, bus.rd_ready, bus.mem_cen_out, bus.mem_wen_out}); end
        checks++; if (bus.mem_addr_out !== 8'h00 || bus.mem_data_out !== '0) begin errors++; $display("FAIL reset_mem_bus: got addr %h data %h exp 0", bus.mem_addr_out, bus.mem_data_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        @(negedge clk);
        bus.wr_valid = 1'b1; bus.wr_addr = 8'h10; bus.wr_data = DA;
        #1;
        checks++; if (bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b0) begin errors++; $display("FAIL write_ready: got wr %b rd %b exp 1 0", bus.wr_ready, bus.rd_ready); end
        checks++; if (bus.mem_cen_out !== 1'b1 || bus.mem_wen_out !== 1'b1) begin errors++; $display("FAIL write_cen_wen: got %b%b exp 11", bus.mem_cen_out, bus.mem_wen_out); end
        checks++; if (bus.mem_addr_out !== 8'h10) begin errors++; $display("FAIL write_addr: got %h exp 10", bus.mem_addr_out); end
        checks++; if (bus.mem_data_out !== DA) begin errors++; $display("FAIL write_data: got %h exp %h", bus.mem_data_out, DA); end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        #1;
        checks++; if (bus.mem_cen_out !== 1'b0 || bus.mem_addr_out !== 8'h00) begin errors++; $display("FAIL write_idle: got cen %b addr %h exp 0 00", bus.mem_cen_out, bus.mem_addr_out); end
    endtask

    task automatic test_read_latency();
        @(negedge clk);
        bus.rd_valid = 1'b1; bus.rd_addr = 8'h10; bus.rd_data_ready = 1'b1;
        #1;
        checks++; if (bus.rd_ready !== 1'b1 || bus.mem_cen_out !== 1'b1 || bus.mem_wen_out !== 1'b0) begin errors++; $display("FAIL read_grant: got rdy %b cen %b wen %b exp 1 1 0", bus.rd_ready, bus.mem_cen_out, bus.mem_wen_out); end
        checks++; if (bus.mem_addr_out !== 8'h10) begin errors++; $display("FAIL read_addr: got %h exp 10", bus.mem_addr_out); end
        @(negedge clk);
        bus.rd_valid = 1'b0;
        #1;
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL read_n1_valid: got %b exp 0", bus.rd_data_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.rd_data_valid !== 1'b1) begin errors++; $display("FAIL read_n2_valid: got %b exp 1", bus.rd_data_valid); end
        checks++; if (bus.rd_data !== DA) begin errors++; $display("FAIL read_n2_data: got %h exp %h", bus.rd_data, DA); end
        @(negedge clk);
        #1;
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL read_popped: got %b exp 0", bus.rd_data_valid); end
    endtask

    task automatic test_conflict();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.wr_valid = 1'b1; bus.wr_addr = 8'h20; bus.wr_data = D20;
            bus.rd_valid = 1'b1; bus.rd_addr = 8'h20; bus.rd_data_ready = 1'b1;
            #1;
            checks++;
            if (bus.wr_ready !== (i % 2 == 0) || bus.rd_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL conflict_cycle%0d: got wr %b rd %b exp wr %b rd %b", i, bus.wr_ready, bus.rd_ready, (i % 2 == 0), (i % 2 == 1));
            end
            if (i == 3) begin
                checks++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== D20) begin errors++; $display("FAIL conflict_return: got v %b data %h exp 1 %h", bus.rd_data_valid, bus.rd_data, D20); end
            end
        end
        @(negedge clk);
        idle();
        bus.rd_data_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL conflict_drain: got %b exp 0", bus.rd_data_valid); end
    endtask

    task automatic test_backpressure();
        int grants = 0;
        @(negedge clk);
        bus.wr_valid = 1'b1; bus.wr_addr = 8'h30; bus.wr_data = D30;
        @(negedge clk);
        bus.wr_addr = 8'h31; bus.wr_data = D31;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.rd_data_ready = 1'b0;
        bus.rd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            bus.rd_addr = (grants == 0) ? 8'h30 : 8'h31;
            #1;
            if (bus.rd_ready === 1'b1) grants++;
        end
        checks++; if (grants != 2) begin errors++; $display("FAIL bp_grant_count: got %0d exp 2", grants); end
        checks++; if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL bp_stalled: got %b exp 0", bus.rd_ready); end
        checks++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== D30) begin errors++; $display("FAIL bp_head: got v %b data %h exp 1 %h", bus.rd_data_valid, bus.rd_data, D30); end
        @(negedge clk);
        bus.rd_valid = 1'b0; bus.rd_data_ready = 1'b1;
        #1;
        checks++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== D30) begin errors++; $display("FAIL bp_drain0: got v %b data %h exp 1 %h", bus.rd_data_valid, bus.rd_data, D30); end
        @(negedge clk);
        #1;
        checks++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== D31) begin errors++; $display("FAIL bp_drain1: got v %b data %h exp 1 %h", bus.rd_data_valid, bus.rd_data, D31); end
        @(negedge clk);
        bus.rd_valid = 1'b1; bus.rd_addr = 8'h30;
        #1;
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b exp 0", bus.rd_data_valid); end
        checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b exp 1", bus.rd_ready); end
        @(negedge clk);
        bus.rd_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.wr_valid = 1'b1; bus.wr_addr = 8'h40; bus.wr_data = D40;
        bus.rd_valid = 1'b1; bus.rd_addr = 8'h40; bus.rd_data_ready = 1'b1;
        #1;
        checks++; if (bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_conflict: got wr %b rd %b exp 1 0", bus.wr_ready, bus.rd_ready); end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        #1;
        checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL flush_pre_read: got %b exp 1", bus.rd_ready); end
        @(negedge clk);
        flush = 1'b1; bus.wr_valid = 1'b1;
        #1;
        checks++; if ({bus.wr_ready, bus.rd_ready, bus.mem_cen_out} !== 3'b000) begin errors++; $display("FAIL flush_no_grant: got %b exp 000", {bus.wr_ready, bus.rd_ready, bus.mem_cen_out}); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b exp 0", bus.rd_data_valid); end
        checks++; if (bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b0) begin errors++; $display("FAIL flush_last_grant: got wr %b rd %b exp 1 0", bus.wr_ready, bus.rd_ready); end
        @(negedge clk);
        #1;
        checks++; if (bus.rd_ready !== 1'b1 || bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL flush_post_rr: got rd %b v %b exp 1 0", bus.rd_ready, bus.rd_data_valid); end
        @(negedge clk);
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clk_en();
        @(negedge clk);
        bus.rd_valid = 1'b1; bus.rd_addr = 8'h10; bus.rd_data_ready = 1'b0;
        @(negedge clk);
        bus.rd_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.rd_data_valid !== 1'b1) begin errors++; $display("FAIL clken_setup: got %b exp 1", bus.rd_data_valid); end
        @(negedge clk);
        clk_en = 1'b0; bus.rd_data_ready = 1'b1;
        bus.rd_valid = 1'b1; bus.wr_valid = 1'b1; bus.wr_addr = 8'h10; bus.wr_data = D20;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if ({bus.wr_ready, bus.rd_ready, bus.mem_cen_out} !== 3'b000 || bus.rd_data_valid !== 1'b1) begin
                errors++;
                $display("FAIL clken_frozen%0d: got grants %b valid %b exp 000 1", i, {bus.wr_ready, bus.rd_ready, bus.mem_cen_out}, bus.rd_data_valid);
            end
        end
        @(negedge clk);
        clk_en = 1'b1; bus.rd_valid = 1'b0; bus.wr_valid = 1'b0;
        #1;
        checks++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== DA) begin errors++; $display("FAIL clken_resume: got v %b data %h exp 1 %h", bus.rd_data_valid, bus.rd_data, DA); end
        @(negedge clk);
        #1;
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL clken_popped: got %b exp 0", bus.rd_data_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.rd_valid = 1'b1; bus.rd_addr = 8'h10; bus.rd_data_ready = 1'b1;
        @(negedge clk);
        bus.rd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_async: got %b exp 0", bus.rd_data_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_lost: got %b exp 0", bus.rd_data_valid); end
        @(negedge clk);
        bus.rd_valid = 1'b1;
        @(negedge clk);
        bus.rd_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== DA) begin errors++; $display("FAIL reset_mid_bank: got v %b data %h exp 1 %h", bus.rd_data_valid, bus.rd_data, DA); end
        @(negedge clk);
    endtask

    initial begin
        bus.mem_data_in = '0;
        test_reset();
        test_write();
        test_read_latency();
        test_conflict();
        test_backpressure();
        test_flush();
        test_clk_en();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
